fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_queue.sv | 166 ++++++++++++++++
 tb/tb_fetch_queue.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// The optional same-cycle bypass in fetch_queue is enabled by FETCHQ_BYPASS_EN.
package fetch_pkg;

    localparam int                WORD_W           = 32;
    localparam logic [WORD_W-1:0] PC_INC           = 32'd4;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fq_entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used both for fetched instructions and for the
// in-flight request PC tags. Flush has priority over push; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues sequential word requests to instruction
// memory (req/gnt, in-order rvalid), buffers responses with their PCs and
// hands them to decode with a valid/ready handshake. A redirect flushes the
// buffer and marks every still-outstanding response to be dropped.
// Optional same-cycle response bypass: define FETCHQ_BYPASS_EN.
//
// Handshakes: a request transfers when imem_req && imem_gnt at a clock edge;
// an instruction transfers to decode when instr_valid && instr_ready at a
// clock edge. imem_req is never withdrawn because of imem_gnt.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int FCW   = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(DEPTH + MAX_OUT + 1) + 1;

    // run holds requests off until the first edge after reset release
    logic              run;
    logic [WORD_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  out_cnt_nxt;
    logic [SW-1:0]     committed;

    logic req_fire;
    logic rsp_ok;
    logic rsp_drop;
    logic rsp_keep;
    logic bypass;
    logic fifo_push;
    logic fifo_pop;

    fq_entry_t         fifo_din;
    fq_entry_t         fifo_head;
    logic [FCW-1:0]    fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic [WORD_W-1:0] tag_pc;
    logic [CNT_W-1:0]  tag_count;
    logic              tag_full;
    logic              tag_empty;

    // Slots already promised: buffered entries plus responses still to be kept.
    assign committed = SW'(fifo_count) + SW'(out_cnt) - SW'(drop_cnt);

    assign imem_req  = run && !redirect && (out_cnt < CNT_W'(MAX_OUT))
                       && (committed < SW'(DEPTH));
    assign imem_addr = fetch_pc;
    assign req_fire  = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok      = imem_rvalid && (out_cnt != '0);
    assign rsp_drop    = rsp_ok && (drop_cnt != '0);
    assign rsp_keep    = rsp_ok && (drop_cnt == '0);
    assign out_cnt_nxt = out_cnt + CNT_W'(req_fire) - CNT_W'(rsp_ok);

`ifdef FETCHQ_BYPASS_EN
    assign bypass      = rsp_keep && fifo_empty && instr_ready;
    assign instr_valid = !fifo_empty || bypass;
    assign instr       = !fifo_empty ? fifo_head.instr : (bypass ? imem_rdata : '0);
    assign instr_pc    = !fifo_empty ? fifo_head.pc    : (bypass ? tag_pc     : '0);
`else
    assign bypass      = 1'b0;
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? '0 : fifo_head.instr;
    assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;
`endif

    assign fifo_push = rsp_keep && !bypass;
    assign fifo_pop  = !fifo_empty && instr_ready;
    assign fifo_din  = '{instr: imem_rdata, pc: tag_pc};

    fetch_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect),
        .din   (fifo_din),
        .count (fifo_count),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // PC tags follow requests in order; dropped responses still consume a tag.
    fetch_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .pop   (rsp_ok),
        .flush (1'b0),
        .din   (fetch_pc),
        .count (tag_count),
        .head  (tag_pc),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // Fetch PC, start-up flag and outstanding/drop counters; redirect wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run      <= 1'b0;
            fetch_pc <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            run     <= 1'b1;
            out_cnt <= out_cnt_nxt;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                drop_cnt <= out_cnt_nxt;
            end else begin
                if (req_fire) fetch_pc <= next_pc(fetch_pc);
                if (rsp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    // Simulation checks on the memory protocol and counter ranges.
    always @(posedge clk) begin
        if (reset) begin
            assert (!(imem_rvalid && out_cnt == '0))
                else $error("fetch_queue: imem_rvalid with no request outstanding");
            assert (!(req_fire && !rsp_ok && out_cnt == CNT_W'(MAX_OUT)))
                else $error("fetch_queue: outstanding counter overrun");
            assert (drop_cnt <= out_cnt)
                else $error("fetch_queue: drop count exceeds outstanding count");
            assert (tag_count == out_cnt)
                else $error("fetch_queue: tag queue out of step with outstanding count");
            assert (!(req_fire && tag_full))
                else $error("fetch_queue: tag queue overrun");
            assert (!(rsp_ok && tag_empty))
                else $error("fetch_queue: response without a tag");
            assert (!(fifo_push && fifo_full && !fifo_pop))
                else $error("fetch_queue: instruction FIFO overrun");
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model and an
// in-order instruction memory responder.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk         = 1'b0;
    logic        reset       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed pattern derived from the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // ---------------- memory responder state ----------------
    logic [31:0] pend_q[$];
    bit          resp_en = 1'b1;
    bit          late_rv = 1'b0;
    logic        s_req;
    logic [31:0] s_addr;

    // ---------------- reference model ----------------
    logic [31:0] m_pc   = RESET_PC;
    bit          m_run  = 1'b0;
    logic [31:0] infl_pc[$];
    bit          infl_stale[$];
    logic [63:0] exp_q[$];
    bit          e_req;
    bit          e_valid;
    bit          e_bypass;
    logic [63:0] e_head;
    int          live;
    logic [31:0] t_pc;
    bit          t_st;

    // Scoreboard: compute expected outputs and compare, away from the edge.
    always @(negedge clk) begin
        s_req  = imem_req;
        s_addr = imem_addr;
        if (!reset) begin
            e_req    = 1'b0;
            e_valid  = 1'b0;
            e_bypass = 1'b0;
            check1 ("rst_req",   imem_req,    1'b0);
            check1 ("rst_valid", instr_valid, 1'b0);
            check32("rst_addr",  imem_addr,   RESET_PC);
            check32("rst_instr", instr,       32'h0);
            check32("rst_pc",    instr_pc,    32'h0);
        end else begin
            live = 0;
            foreach (infl_stale[i]) if (!infl_stale[i]) live++;
            e_req = m_run && !redirect && (infl_pc.size() < MAX_OUT)
                    && (exp_q.size() + live < DEPTH);
            e_bypass = 1'b0;
`ifdef FETCHQ_BYPASS_EN
            if (exp_q.size() == 0 && infl_pc.size() > 0)
                e_bypass = imem_rvalid && instr_ready && !infl_stale[0];
`endif
            e_valid = (exp_q.size() > 0) || e_bypass;
            if (exp_q.size() > 0)  e_head = exp_q[0];
            else if (e_bypass)     e_head = {imem_rdata, infl_pc[0]};
            else                   e_head = 64'h0;
            check1 ("cmp_req",   imem_req,    e_req);
            check32("cmp_addr",  imem_addr,   m_pc);
            check1 ("cmp_valid", instr_valid, e_valid);
            if (e_valid) begin
                check32("cmp_instr", instr,    e_head[63:32]);
                check32("cmp_pc",    instr_pc, e_head[31:0]);
            end
        end
    end

    // Model and memory update at the clock edge, then drive the next response.
    always @(posedge clk) begin
        if (!reset) begin
            pend_q.delete();
            infl_pc.delete();
            infl_stale.delete();
            exp_q.delete();
            m_pc  = RESET_PC;
            m_run = 1'b0;
        end else begin
            if (imem_rvalid && pend_q.size() > 0) void'(pend_q.pop_front());
            if (s_req && imem_gnt) pend_q.push_back(s_addr);

            if (e_valid && instr_ready && !e_bypass) void'(exp_q.pop_front());
            if (imem_rvalid && infl_pc.size() > 0) begin
                t_pc = infl_pc.pop_front();
                t_st = infl_stale.pop_front();
                if (!t_st && !redirect && !e_bypass) exp_q.push_back({imem_rdata, t_pc});
            end
            if (e_req && imem_gnt) begin
                infl_pc.push_back(m_pc);
                infl_stale.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
            if (redirect) begin
                exp_q.delete();
                foreach (infl_stale[i]) infl_stale[i] = 1'b1;
                m_pc = redirect_pc;
            end
            m_run = 1'b1;
        end
        #2;
        imem_rvalid = (resp_en && reset && pend_q.size() > 0) || late_rv;
        imem_rdata  = (pend_q.size() > 0) ? mem_word(pend_q[0]) : 32'h0;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!instr_valid) begin
            errors++;
            $display("FAIL %s: instr_valid low after 20 cycles, required 1", name);
        end
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = pc;
        @(posedge clk); #1;
        redirect    = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge clk);

        // Streaming: grant every cycle, response one cycle later, decode ready.
        #1;
        reset       = 1'b1;
        imem_gnt    = 1'b1;
        resp_en     = 1'b1;
        instr_ready = 1'b1;
        #1;
        check1("c0_req_idle", imem_req, 1'b0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        check1 ("c2_valid", instr_valid, 1'b0);
        check32("c2_addr",  imem_addr,   32'h0000_0004);
        @(posedge clk); @(negedge clk);
        check1 ("c3_valid", instr_valid, 1'b1);
        check32("c3_pc",    instr_pc,    32'h0000_0000);
        check32("c3_instr", instr,       32'hC0DE_0000);
        @(negedge clk);
        check32("c4_pc",    instr_pc,    32'h0000_0004);
        check32("c4_instr", instr,       32'hC0DE_0004);
        @(negedge clk);
        check32("c5_pc",    instr_pc,    32'h0000_0008);
        repeat (4) @(posedge clk);

        // Asynchronous reset with two requests outstanding.
        @(posedge clk); #1;
        resp_en = 1'b0;
        @(posedge clk); @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check1 ("arst_req",   imem_req,    1'b0);
        check32("arst_addr",  imem_addr,   RESET_PC);
        check1 ("arst_valid", instr_valid, 1'b0);
        check32("arst_instr", instr,       32'h0);
        check32("arst_pc",    instr_pc,    32'h0);
        instr_ready = 1'b0;
        @(posedge clk); #1;
        late_rv = 1'b1;
        @(posedge clk); #1;
        late_rv = 1'b0;
        resp_en = 1'b1;
        @(posedge clk); #1;

        // Decode stalled: exactly DEPTH entries buffered, then drained in order.
        reset = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check1 ("full_req",   imem_req,    1'b0);
        check32("full_addr",  imem_addr,   32'h0000_0010);
        check1 ("full_valid", instr_valid, 1'b1);
        check32("full_pc",    instr_pc,    32'h0000_0000);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        @(negedge clk); check32("drain_pc0", instr_pc, 32'h0000_0000);
        @(negedge clk); check32("drain_pc1", instr_pc, 32'h0000_0004);
        @(negedge clk); check32("drain_pc2", instr_pc, 32'h0000_0008);
        @(negedge clk); check32("drain_pc3", instr_pc, 32'h0000_000C);
        @(negedge clk); check32("drain_pc4", instr_pc, 32'h0000_0010);
        repeat (4) @(posedge clk);

        // Redirect with two responses outstanding and one entry buffered.
        @(posedge clk); #1;
        resp_en     = 1'b0;
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("pre_rd_req",   imem_req,    1'b0);
        check1("pre_rd_valid", instr_valid, 1'b1);
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        check1("rd_req", imem_req, 1'b0);
        @(posedge clk); #1;
        redirect    = 1'b0;
        resp_en     = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        check1("post_rd_valid", instr_valid, 1'b0);
        wait_valid("rd100_wait");
        check32("rd100_pc",    instr_pc, 32'h0000_0100);
        check32("rd100_instr", instr,    32'hC0DE_0100);
        @(negedge clk);
        check32("rd104_pc",    instr_pc, 32'h0000_0104);
        repeat (6) @(posedge clk);

        // Redirect in the same cycle as a response, one outstanding.
        pulse_redirect(32'h0000_0200);
        wait_valid("rd200_wait");
        check32("rd200_pc", instr_pc, 32'h0000_0200);
        repeat (6) @(posedge clk);

        // Back-to-back redirects: the last one wins.
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(posedge clk); #1;
        redirect_pc = 32'h0000_0400;
        @(posedge clk); #1;
        redirect    = 1'b0;
        wait_valid("rd400_wait");
        check32("rd400_pc", instr_pc, 32'h0000_0400);
        repeat (6) @(posedge clk);

        // Address wrap at the top of the 32-bit space.
        pulse_redirect(32'hFFFF_FFF8);
        @(negedge clk);
        check1 ("wrap_req",   imem_req,  1'b1);
        check32("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        check32("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check32("wrap_addr2", imem_addr, 32'h0000_0000);
        check32("wrap_pc0",   instr_pc,  32'hFFFF_FFF8);
        @(negedge clk);
        check32("wrap_pc1",   instr_pc,  32'hFFFF_FFFC);
        @(negedge clk);
        check32("wrap_pc2",   instr_pc,  32'h0000_0000);

        // Mixed traffic with stalls, grant gaps and occasional redirects.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            imem_gnt    = ($urandom_range(0, 3) != 0);
            resp_en     = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        end
        @(posedge clk); #1;
        redirect    = 1'b0;
        imem_gnt    = 1'b1;
        resp_en     = 1'b1;
        instr_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
